timer_key_loader: RTL

- Writer side of the microwave countdown timer's digit-load interface.
- Accepts keypad codes over a valid/ready handshake and keeps a shadow copy of the M:SS entry.
- Validates each key, then drives the timer's shift-load port with one digit per load pulse, so digits enter at seconds-ones and shift toward minutes.
- Also issues timer clear and start requests.

---
 rtl/timer_key_loader.sv | 126 ++++++++++++
 1 files changed

// File: rtl/timer_key_loader.sv
// Keypad-side loader for the microwave countdown timer: validates M:SS digit
// entry, shift-loads digits into the timer and issues clear/start requests.
module timer_key_loader #(
  parameter int unsigned MAX_TENS  = 5,
  parameter logic [3:0]  KEY_CLEAR = 4'hA,
  parameter logic [3:0]  KEY_START = 4'hB
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       running,
  output logic [3:0] timer_data,
  output logic       timer_loadn,
  output logic       timer_clearn,
  output logic       start_req,
  output logic       key_err,
  output logic [3:0] entry_ones,
  output logic [3:0] entry_tens,
  output logic [3:0] entry_mins
);

  localparam logic [3:0] MAX_TENS_C = 4'(MAX_TENS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CLR  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       key_accept, is_digit, digit_ok, shadow_zero;
  logic [3:0] data_nxt, ones_nxt, tens_nxt, mins_nxt;
  logic       loadn_nxt, clearn_nxt, start_nxt, err_nxt, ready_nxt;

  assign key_accept  = key_valid & key_ready;
  assign is_digit    = (key_code <= 4'd9);
  // A new digit shifts ones into tens, so ones must already be a legal tens digit.
  assign digit_ok    = !running && (entry_mins == 4'd0) && (entry_ones <= MAX_TENS_C);
  assign shadow_zero = (entry_ones == 4'd0) && (entry_tens == 4'd0) && (entry_mins == 4'd0);

  // State register plus the registered outputs computed one cycle ahead.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= CLR;
      timer_data   <= 4'd0;
      timer_loadn  <= 1'b1;
      timer_clearn <= 1'b0;
      start_req    <= 1'b0;
      key_err      <= 1'b0;
      key_ready    <= 1'b0;
      entry_ones   <= 4'd0;
      entry_tens   <= 4'd0;
      entry_mins   <= 4'd0;
    end else begin
      state        <= state_nxt;
      timer_data   <= data_nxt;
      timer_loadn  <= loadn_nxt;
      timer_clearn <= clearn_nxt;
      start_req    <= start_nxt;
      key_err      <= err_nxt;
      key_ready    <= ready_nxt;
      entry_ones   <= ones_nxt;
      entry_tens   <= tens_nxt;
      entry_mins   <= mins_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE: begin
        state_nxt = IDLE;
        if (key_accept) begin
          if (is_digit && digit_ok)      state_nxt = LOAD;
          else if (key_code == KEY_CLEAR) state_nxt = CLR;
        end
      end
      LOAD:    state_nxt = IDLE;
      CLR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: strobes default inactive, shadow and timer_data hold.
  always_comb begin
    data_nxt   = timer_data;
    ones_nxt   = entry_ones;
    tens_nxt   = entry_tens;
    mins_nxt   = entry_mins;
    loadn_nxt  = 1'b1;
    clearn_nxt = 1'b1;
    start_nxt  = 1'b0;
    err_nxt    = 1'b0;
    ready_nxt  = (state_nxt == IDLE);
    if (state == IDLE && key_accept) begin
      if (is_digit) begin
        if (digit_ok) begin
          mins_nxt  = entry_tens;
          tens_nxt  = entry_ones;
          ones_nxt  = key_code;
          data_nxt  = key_code;
          loadn_nxt = 1'b0;
        end else begin
          err_nxt = 1'b1;
        end
      end else if (key_code == KEY_CLEAR) begin
        ones_nxt   = 4'd0;
        tens_nxt   = 4'd0;
        mins_nxt   = 4'd0;
        clearn_nxt = 1'b0;
      end else if (key_code == KEY_START) begin
        if (!running && !shadow_zero) start_nxt = 1'b1;
        else                          err_nxt   = 1'b1;
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

endmodule
